video_pixel_packer: RTL

- Deserialiser for the video pixel path: accepts a stream of 2-bit pixel codes, MSB-first, and packs each group of four into one byte for the frame-capture/memory-writer side.
- Exact inverse of the video shift register: the first pixel received lands in data[7:6], matching the shifter, which emits data[7:6] first.
- Sits between the pixel source and the byte-wide memory write port, with a valid/ready handshake on the byte side.

---
 rtl/video_pixel_packer_pkg.sv | 12 +
 rtl/video_sample_strobe.sv | 17 +
 rtl/video_pixel_packer.sv | 87 ++++++++
 3 files changed

// File: rtl/video_pixel_packer_pkg.sv
// Shared constants for the video pixel path (shift register and packer).
package video_pixel_packer_pkg;
  localparam int PIXEL_WIDTH     = 2;
  localparam int BYTE_WIDTH      = 8;
  localparam int PIXELS_PER_BYTE = BYTE_WIDTH / PIXEL_WIDTH;

  function automatic int count_width(input int ppb);
    return (ppb > 1) ? $clog2(ppb) : 1;
  endfunction

  localparam int COUNT_WIDTH = count_width(PIXELS_PER_BYTE);
endpackage

// File: rtl/video_sample_strobe.sv
// Pixel-rate strobe: every clk, or every second clk when div2 is set.
module video_sample_strobe (
  input  logic clk,
  input  logic reset,
  input  logic div2,
  output logic strobe
);
  logic phase;

  // phase free-runs so a div2 change never realigns the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= 1'b0;
    else       phase <= ~phase;
  end

  assign strobe = ~div2 | phase;
endmodule

// File: rtl/video_pixel_packer.sv
// Packs MSB-first pixel codes into bytes; first pixel lands in the top bits.
module video_pixel_packer
  import video_pixel_packer_pkg::*;
#(
  parameter int PIXEL_WIDTH = video_pixel_packer_pkg::PIXEL_WIDTH,
  parameter int BYTE_WIDTH  = video_pixel_packer_pkg::BYTE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   div2,
  input  logic                   lineStart,
  input  logic                   pixelValid,
  input  logic [PIXEL_WIDTH-1:0] pixelData,
  input  logic                   dataReady,
  output logic [BYTE_WIDTH-1:0]  data,
  output logic                   dataValid,
  output logic                   overflow,
  input  logic                   overflowClear
);
  localparam int PPB = BYTE_WIDTH / PIXEL_WIDTH;
  localparam int CW  = count_width(PPB);
  localparam int AW  = BYTE_WIDTH - PIXEL_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(PPB - 1);

  logic                  strobe, sample, last, complete, load;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [BYTE_WIDTH-1:0] shifted;

  video_sample_strobe u_strobe (
    .clk    (clk),
    .reset  (reset),
    .div2   (div2),
    .strobe (strobe)
  );

  // Only the low AW bits of the accumulator are ever visible in a byte.
  assign sample   = strobe & pixelValid;
  assign shifted  = {acc_q, pixelData};
  assign last     = (count_q == LAST);
  assign complete = sample & last & ~lineStart;
  assign load     = complete & (~dataValid | dataReady);

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (lineStart) begin
      acc_d   = '0;
      count_d = '0;
      if (sample) begin
        acc_d   = AW'(pixelData);
        count_d = CW'(1);
      end
    end else if (sample) begin
      acc_d   = shifted[AW-1:0];
      count_d = last ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  // A byte that completes while the held byte is still unaccepted is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      dataValid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        data      <= shifted;
        dataValid <= 1'b1;
      end else if (dataValid && dataReady) begin
        dataValid <= 1'b0;
      end
      if (complete && dataValid && !dataReady) overflow <= 1'b1;
      else if (overflowClear)                  overflow <= 1'b0;
    end
  end
endmodule
